vec_alu_lane_sequencer: RTL and testbench
=========================================

# vec_alu_lane_sequencer

Sequential initiator for the single-element vector ALU (`alu_element_vec`). It accepts one vector operation per request over a valid/ready handshake. It then feeds the element pairs one per cycle into an external `alu_element_vec` instance and gathers the element results into a packed result vector. The full vector is returned on a valid/ready response channel. It sits between the vector execute stage's operand read and its writeback.

## Interface
- ELEMENT_SIZE, 16, width of one vector element and of the ALU datapath.
- NUM_ELEMENTS, 8, elements per vector. Must be ≥ 2. The index counter is $clog2(NUM_ELEMENTS) bits wide.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  ALU select code, forwarded unchanged to `sel`.
- req_vecA  in  NUM_ELEMENTS*ELEMENT_SIZE  operand A; element i in bits [i*ELEMENT_SIZE +: ELEMENT_SIZE].
- req_vecB  in  NUM_ELEMENTS*ELEMENT_SIZE  operand B; same packing.
- elementA  out  ELEMENT_SIZE  to ALU elementA.
- elementB  out  ELEMENT_SIZE  to ALU elementB.
- sel  out  3  to ALU sel.
- alu_result  in  ELEMENT_SIZE  from ALU result (combinational path through ALU).
- rsp_valid  out  1  result vector available.
- rsp_ready  in  1  consumer takes result.
- rsp_vec  out  NUM_ELEMENTS*ELEMENT_SIZE  result vector; same packing as operands.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch req_vecA, req_vecB and req_op;
  - set idx=0;
  - go to RUN.
- RUN: drive elementA=vecA[idx], elementB=vecB[idx] and sel=op, all from registers. Each edge:
  - write alu_result into rsp_vec slice idx;
  - if idx==NUM_ELEMENTS-1, go to DONE; otherwise idx+1.
- DONE: rsp_valid=1, with rsp_vec stable. On rsp_ready, go to IDLE.
- No arithmetic inside the block. Opcode meaning belongs to the ALU: 000 add, 001 sub, 010 mul (low ELEMENT_SIZE bits), 011 asr, 100 lsr, 101 lsl, 110 and. Code 111 is forwarded as-is.
- Element order is fixed: 0 first, ascending.
- Operand registers are written only on request acceptance. Changes on req_* outside acceptance are ignored.
- Outputs in IDLE and DONE: elementA=0, elementB=0, sel=0.

## Timing
- Reset values: req_ready=0 while rst_n low, then 1 in IDLE. Also cleared by reset:
  - rsp_valid=0, busy=0;
  - rsp_vec=0, elementA=0, elementB=0, sel=0;
  - idx=0, state IDLE.
- Acceptance edge E0. Elements 0..NUM_ELEMENTS-1 are captured on edges E1..E_N.
- rsp_valid rises after E_N, so latency from accept to rsp_valid is NUM_ELEMENTS cycles.
- rsp handshake at edge F returns to IDLE. req_ready is 1 in the following cycle, so at least one dead cycle separates responses. Throughput is at most one vector per NUM_ELEMENTS+2 cycles.
- req_ready is 0 in RUN and DONE, so a request during busy is not accepted and must be held by the requester.
- rsp_ready held low: stay in DONE indefinitely, with rsp_vec and rsp_valid stable.
- rsp_ready high before DONE: no effect.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE with all outputs at reset values. The partial result is discarded and no response is issued.
- Counter wrap: idx never exceeds NUM_ELEMENTS-1. It returns to 0 only on a new acceptance.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0 and busy=0 throughout; no acceptance.
- Add, default params: A elements all 8, B elements all 5, op=000 -> rsp_valid exactly 8 cycles after accept; every rsp_vec element 13.
- Per-element order: A[i]=i+10, B[i]=i, op=001 -> every element 10. Monitor shows elementA=10,11,…,17 on consecutive RUN cycles.
- Mul/shift/and: three back-to-back requests.
  - A=5,B=6 op=010 -> 30.
  - A=32,B=2 op=100 -> 8.
  - A=15,B=10 op=110 -> 10.
  - req_ready is low during each busy period, with exactly one dead cycle between rsp handshake and next accept.
- Backpressure: keep rsp_ready=0 for 20 cycles after rsp_valid -> rsp_vec unchanged and busy=1. Then pulse rsp_ready -> rsp_valid=0 next cycle.
- Mid-op reset: drive rst_n low at RUN idx=3 -> outputs zero asynchronously, no rsp_valid. Then a new request (A=4,B=2 op=101) -> all elements 16.

Source files
------------

// File: rtl/vec_alu_lane_sequencer.sv
// Sequencer that streams vector element pairs one per cycle through an external
// single-element ALU and gathers the element results into a packed response vector.
module vec_alu_lane_sequencer #(
    parameter int unsigned ELEMENT_SIZE = 16,
    parameter int unsigned NUM_ELEMENTS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [2:0]                           req_op,
    input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] req_vecA,
    input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] req_vecB,
    output logic [ELEMENT_SIZE-1:0]              elementA,
    output logic [ELEMENT_SIZE-1:0]              elementB,
    output logic [2:0]                           sel,
    input  logic [ELEMENT_SIZE-1:0]              alu_result,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] rsp_vec,
    output logic                                 busy
);

    localparam int unsigned IdxW = $clog2(NUM_ELEMENTS);
    localparam int unsigned VecW = NUM_ELEMENTS * ELEMENT_SIZE;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic [IdxW-1:0]         next_idx;
    logic [VecW-1:0]         vec_a_q;
    logic [VecW-1:0]         vec_b_q;
    logic [VecW-1:0]         rsp_vec_q;
    logic [ELEMENT_SIZE-1:0] element_a_q;
    logic [ELEMENT_SIZE-1:0] element_b_q;
    logic [2:0]              sel_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic                    busy_q;

    assign next_idx = idx_q + IdxW'(1);

    // Element outputs are preloaded one edge ahead so the ALU sees vecA/vecB[idx]
    // from a register during the RUN cycle that owns idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            vec_a_q     <= '0;
            vec_b_q     <= '0;
            rsp_vec_q   <= '0;
            element_a_q <= '0;
            element_b_q <= '0;
            sel_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        vec_a_q     <= req_vecA;
                        vec_b_q     <= req_vecB;
                        idx_q       <= '0;
                        element_a_q <= req_vecA[ELEMENT_SIZE-1:0];
                        element_b_q <= req_vecB[ELEMENT_SIZE-1:0];
                        sel_q       <= req_op;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StRun;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    rsp_vec_q[idx_q*ELEMENT_SIZE +: ELEMENT_SIZE] <= alu_result;
                    if (idx_q == LastIdx) begin
                        element_a_q <= '0;
                        element_b_q <= '0;
                        sel_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q       <= next_idx;
                        element_a_q <= vec_a_q[next_idx*ELEMENT_SIZE +: ELEMENT_SIZE];
                        element_b_q <= vec_b_q[next_idx*ELEMENT_SIZE +: ELEMENT_SIZE];
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign elementA  = element_a_q;
    assign elementB  = element_b_q;
    assign sel       = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_vec   = rsp_vec_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vec_alu_lane_sequencer.sv
// Self-checking bench: a behavioural ALU closes the loop, a per-element vector
// model supplies expected results for directed table cases and random requests.
module tb_vec_alu_lane_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned VW = N * W;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_case_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    vec_t         req_vecA;
    vec_t         req_vecB;
    logic [W-1:0] elementA;
    logic [W-1:0] elementB;
    logic [2:0]   sel;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    vec_t         rsp_vec;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] elem_log [N];

    always #5 clk = ~clk;

    vec_alu_lane_sequencer #(.ELEMENT_SIZE(W), .NUM_ELEMENTS(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_vecA   (req_vecA),
        .req_vecB   (req_vecB),
        .elementA   (elementA),
        .elementB   (elementB),
        .sel        (sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_vec    (rsp_vec),
        .busy       (busy)
    );

    // Behaviour of the external single-element ALU; code 111 is given an xor here.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a * b;
            3'd3:    r = $signed(a) >>> b;
            3'd4:    r = a >> b;
            3'd5:    r = a << b;
            3'd6:    r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_fn(elementA, elementB, sel);

    function automatic vec_t model_vec(input vec_t a, input vec_t b, input logic [2:0] op);
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = alu_fn(a[i*W +: W], b[i*W +: W], op);
        return r;
    endfunction

    function automatic vec_t splat(input logic [W-1:0] e);
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = e;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one request from a negedge and completes its response handshake.
    task automatic do_op(input vec_t a, input vec_t b, input logic [2:0] op, input int stall,
                         input bit early, output vec_t res, output int lat, output int wait_cyc);
        int ready_bad;
        int stall_bad;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("req_ready_avail", req_ready, 1);
        req_valid = 1'b1;
        req_vecA  = a;
        req_vecB  = b;
        req_op    = op;
        @(negedge clk);
        // Held valid with junk payload while busy must not disturb the operation.
        req_vecA  = rand_vec();
        req_vecB  = rand_vec();
        req_op    = 3'($urandom);
        rsp_ready = early;
        lat = 0;
        ready_bad = 0;
        while (!rsp_valid && lat < 40) begin
            if (lat < N) elem_log[lat] = elementA;
            if (req_ready || !busy) ready_bad++;
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        res = rsp_vec;
        chk("latency", lat, N);
        chk("ready_low_busy", ready_bad, 0);
        chk("done_outputs_zero", {elementA, elementB, sel}, 0);
        if (!early) begin
            stall_bad = 0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (rsp_vec !== res || !busy || !rsp_valid || req_ready) stall_bad++;
            end
            chk("stall_stable", stall_bad, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
        chk("busy_after_rsp", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_case_t tbl[5];
        vec_t a, b, res;
        int lat, wc, bad;
        logic [2:0] op;

        tbl[0] = '{a: 16'd8,  b: 16'd5,  op: 3'b000, exp: 16'd13};
        tbl[1] = '{a: 16'd5,  b: 16'd6,  op: 3'b010, exp: 16'd30};
        tbl[2] = '{a: 16'd32, b: 16'd2,  op: 3'b100, exp: 16'd8};
        tbl[3] = '{a: 16'd15, b: 16'd10, op: 3'b110, exp: 16'd10};
        tbl[4] = '{a: 16'd4,  b: 16'd2,  op: 3'b101, exp: 16'd16};

        rst_n = 1'b0;
        req_valid = 1'b1;
        req_op = 3'd0;
        req_vecA = splat(16'd1);
        req_vecB = splat(16'd2);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_flags", {req_ready, rsp_valid, busy}, 0);
            chk("reset_data", {rsp_vec, elementA, elementB, sel}, 0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {req_ready, busy, rsp_valid}, 3'b100);

        // Add case with 20 cycles of response backpressure.
        do_op(splat(tbl[0].a), splat(tbl[0].b), tbl[0].op, 20, 1'b0, res, lat, wc);
        chk("add_result", res, splat(tbl[0].exp));

        // Element order: elementA must walk 10..17.
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = W'(i + 10);
            b[i*W +: W] = W'(i);
        end
        do_op(a, b, 3'b001, 0, 1'b0, res, lat, wc);
        chk("sub_result", res, splat(16'd10));
        bad = 0;
        for (int i = 0; i < N; i++) if (elem_log[i] !== W'(i + 10)) bad++;
        chk("element_order", bad, 0);

        // Back-to-back mul / lsr / and: one dead cycle before each accept.
        for (int t = 1; t <= 3; t++) begin
            do_op(splat(tbl[t].a), splat(tbl[t].b), tbl[t].op, 0, 1'b0, res, lat, wc);
            chk("table_result", res, splat(tbl[t].exp));
            chk("dead_cycle", wc, 0);
        end

        // Reset while RUN is at idx 3.
        for (int i = 0; i < N; i++) a[i*W +: W] = W'(i + 100);
        req_valid = 1'b1;
        req_vecA = a;
        req_vecB = splat(16'd1);
        req_op = 3'b000;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_run_idx3", elementA, 16'd103);
        rst_n = 1'b0;
        #1;
        chk("async_reset_flags", {req_ready, rsp_valid, busy}, 0);
        chk("async_reset_data", {rsp_vec, elementA, elementB, sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        chk("no_rsp_after_reset", bad, 0);
        do_op(splat(tbl[4].a), splat(tbl[4].b), tbl[4].op, 1, 1'b0, res, lat, wc);
        chk("lsl_after_reset", res, splat(tbl[4].exp));

        // Random operands and opcodes against the per-element model.
        for (int r = 0; r < 16; r++) begin
            a = rand_vec();
            b = rand_vec();
            if (r % 3 == 0) for (int i = 0; i < N; i++) b[i*W +: W] = W'($urandom_range(0, 17));
            op = 3'($urandom_range(0, 7));
            do_op(a, b, op, int'($urandom_range(0, 3)), (r % 4 == 0), res, lat, wc);
            chk("random_result", res, model_vec(a, b, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
